// File: rtl/encoder_pl.sv
// ============================================================================
// Module   : encoder_pl
// Brief    : Systematic (19,8) linear block encoder with a valid/ready input,
//            a DEPTH-entry output FIFO and an accepted-word counter.
//            Optional macro ERR_INJECT_EN enables single-bit error injection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_pl #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       d,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [18:0]      cx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt,
    input  logic             inj_en,
    input  logic [4:0]       inj_idx
);

    localparam int           AW     = $clog2(DEPTH);
    localparam logic [AW:0]  c_FULL = (AW+1)'(DEPTH);

    logic [18:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_word_cnt;

    logic [10:0]      w_parity;
    logic [18:0]      w_clean;
    logic [18:0]      w_code;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_parity[0]  = d[1] ^ d[3] ^ d[4] ^ d[5] ^ d[6] ^ d[7];
        w_parity[1]  = d[2] ^ d[3] ^ d[5];
        w_parity[2]  = d[0] ^ d[1] ^ d[3];
        w_parity[3]  = d[3] ^ d[7];
        w_parity[4]  = d[0] ^ d[1] ^ d[4] ^ d[6];
        w_parity[5]  = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[7];
        w_parity[6]  = d[2] ^ d[3] ^ d[5];
        w_parity[7]  = d[0] ^ d[2] ^ d[3];
        w_parity[8]  = d[0] ^ d[1] ^ d[3] ^ d[7];
        w_parity[9]  = d[1] ^ d[4] ^ d[6] ^ d[7];
        w_parity[10] = d[0] ^ d[2] ^ d[3] ^ d[4] ^ d[5];
    end

    assign w_clean = {d, w_parity};

`ifdef ERR_INJECT_EN
    // Out-of-range indices leave the codeword untouched.
    always_comb begin
        w_code = w_clean;
        if (inj_en && (inj_idx < 5'd19)) begin
            w_code = w_clean ^ (19'd1 << inj_idx);
        end
    end
`else
    logic w_unused_inj;
    assign w_unused_inj = ^{inj_en, inj_idx};
    assign w_code       = w_clean;
`endif

    // Ready depends only on stored occupancy, never on out_ready.
    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign cx        = r_mem[r_rptr];
    assign word_cnt  = r_word_cnt;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_word_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_code;
                r_wptr        <= r_wptr + 1'b1;
                r_word_cnt    <= r_word_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire
